// File: rtl/tapa_global_fsm.sv
// tapa_global_fsm: top-level control FSM for the kernel.
// Takes the host ap_ctrl_hs handshake, latches the kernel scalars, broadcasts
// a start pulse to every task FSM, then waits for all task done flags before
// pulsing a global done to the task FSMs and the host.
// Optional RUN-state timeout: define TAPA_GLOBAL_FSM_TIMEOUT_EN.
module tapa_global_fsm #(
  parameter int NUM_TASKS      = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  output logic                 ap_idle,
  output logic                 ap_error,
  input  logic [63:0]          s_output_mmap_offset,
  input  logic [31:0]          s_seq_len,
  output logic [63:0]          global_fsm_s_output_mmap_offset,
  output logic [31:0]          global_fsm_s_seq_len,
  output logic                 global_fsm_ap_start,
  output logic                 global_fsm_ap_done,
  input  logic [NUM_TASKS-1:0] task_is_done,
  output logic [31:0]          run_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    RUN   = 2'b11,
    DONE  = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] offset_q, offset_d;
  logic [31:0] seq_len_q, seq_len_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        all_done;
  logic        timeout_hit;
  logic        accept;

  // Stale done flags are cleared by the task FSMs before RUN, so a plain
  // AND across the vector is enough to detect completion.
  assign all_done = &task_is_done;
  assign accept   = (state_q == IDLE) && ap_start;

`ifdef TAPA_GLOBAL_FSM_TIMEOUT_EN
  localparam logic [32:0] TimeoutLimit = 33'(TIMEOUT_CYCLES);

  logic error_q;

  // run_cycles_q counts the RUN cycles already finished, so +1 is the
  // current one; the extra bit keeps the compare safe at saturation.
  assign timeout_hit = (({1'b0, run_cycles_q} + 33'd1) >= TimeoutLimit);

  // Sticky timeout flag: cleared when the next run is accepted so it reads 0
  // during START, set when RUN gives up without a full done vector.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if ((state_q == RUN) && !all_done && timeout_hit) begin
      error_q <= 1'b1;
    end
  end

  assign ap_error = error_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign ap_error    = 1'b0;
`endif

  // State, latched scalars and RUN-cycle counter; reset forces IDLE at once.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      offset_q     <= 64'd0;
      seq_len_q    <= 32'd0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      seq_len_q    <= seq_len_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Next-state logic: IDLE -> START -> RUN -> DONE -> IDLE, with the scalar
  // latch on acceptance and a saturating cycle count while in RUN.
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    seq_len_d    = seq_len_q;
    run_cycles_d = run_cycles_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          offset_d  = s_output_mmap_offset;
          seq_len_d = s_seq_len;
          state_d   = START;
        end
      end
      START: begin
        run_cycles_d = 32'd0;
        state_d      = RUN;
      end
      RUN: begin
        if (run_cycles_q != 32'hFFFF_FFFF) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end
        if (all_done || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ap_idle                         = (state_q == IDLE);
  assign ap_ready                        = (state_q == START);
  assign global_fsm_ap_start             = (state_q == START);
  assign ap_done                         = (state_q == DONE);
  assign global_fsm_ap_done              = (state_q == DONE);
  assign global_fsm_s_output_mmap_offset = offset_q;
  assign global_fsm_s_seq_len            = seq_len_q;
  assign run_cycles                      = run_cycles_q;

endmodule

// File: tb/tb_tapa_global_fsm.sv
// tb_tapa_global_fsm: self-checking bench for tapa_global_fsm.
// Each invocation is described by the RUN cycle on which each done bit
// rises; the expected handshake timing, run_cycles and error flag follow
// from that plan by plain arithmetic.
// Timeout expectations apply when TAPA_GLOBAL_FSM_TIMEOUT_EN is defined.
module tb_tapa_global_fsm;

  localparam int NumTasks = 4;
  localparam int Timeout  = 16;

  logic                ap_clk = 1'b0;
  logic                ap_rst_n = 1'b0;
  logic                ap_start = 1'b0;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;
  logic                ap_error;
  logic [63:0]         s_output_mmap_offset = 64'd0;
  logic [31:0]         s_seq_len = 32'd0;
  logic [63:0]         global_fsm_s_output_mmap_offset;
  logic [31:0]         global_fsm_s_seq_len;
  logic                global_fsm_ap_start;
  logic                global_fsm_ap_done;
  logic [NumTasks-1:0] task_is_done = '0;
  logic [31:0]         run_cycles;

  int   errors = 0;
  int   checks = 0;
  logic expErr = 1'b0;

  tapa_global_fsm #(
    .NUM_TASKS     (NumTasks),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .ap_clk                         (ap_clk),
    .ap_rst_n                       (ap_rst_n),
    .ap_start                       (ap_start),
    .ap_ready                       (ap_ready),
    .ap_done                        (ap_done),
    .ap_idle                        (ap_idle),
    .ap_error                       (ap_error),
    .s_output_mmap_offset           (s_output_mmap_offset),
    .s_seq_len                      (s_seq_len),
    .global_fsm_s_output_mmap_offset(global_fsm_s_output_mmap_offset),
    .global_fsm_s_seq_len           (global_fsm_s_seq_len),
    .global_fsm_ap_start            (global_fsm_ap_start),
    .global_fsm_ap_done             (global_fsm_ap_done),
    .task_is_done                   (task_is_done),
    .run_cycles                     (run_cycles)
  );

  // 100 MHz free-running clock
  always #5 ap_clk = ~ap_clk;

  // Hard stop in case the bench itself gets stuck
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkCtrl(input string where, input logic idle,
                           input logic ready, input logic done);
    checkOutput({where, ".ap_idle"},  64'(ap_idle),             64'(idle));
    checkOutput({where, ".ap_ready"}, 64'(ap_ready),            64'(ready));
    checkOutput({where, ".g_start"},  64'(global_fsm_ap_start), 64'(ready));
    checkOutput({where, ".ap_done"},  64'(ap_done),             64'(done));
    checkOutput({where, ".g_done"},   64'(global_fsm_ap_done),  64'(done));
    checkOutput({where, ".ap_error"}, 64'(ap_error),            64'(expErr));
  endtask

  task automatic checkResetValues(input string where);
    checkCtrl(where, 1'b1, 1'b0, 1'b0);
    checkOutput({where, ".off"},  global_fsm_s_output_mmap_offset, 64'd0);
    checkOutput({where, ".len"},  64'(global_fsm_s_seq_len),       64'd0);
    checkOutput({where, ".rcyc"}, 64'(run_cycles),                 64'd0);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // One invocation starting from an IDLE cycle. arr[i] is the RUN cycle
  // (1-based) on which done bit i rises. postOff/postLen are driven on the
  // scalar inputs after START and must not disturb the latched values.
  task automatic applyStimulus(input logic [63:0] off, input logic [31:0] len,
                               input int arr[NumTasks], input bit holdStart,
                               input logic [63:0] postOff,
                               input logic [31:0] postLen);
    int lastDone;
    int endCycle;
    bit timedOut;
    lastDone = 0;
    foreach (arr[i]) if (arr[i] > lastDone) lastDone = arr[i];
    endCycle = lastDone;
    timedOut = 1'b0;
`ifdef TAPA_GLOBAL_FSM_TIMEOUT_EN
    if (lastDone > Timeout) begin
      endCycle = Timeout;
      timedOut = 1'b1;
    end
`endif
    checkCtrl("idle_pre", 1'b1, 1'b0, 1'b0);
    s_output_mmap_offset = off;
    s_seq_len            = len;
    ap_start             = 1'b1;
    tick();
    expErr = 1'b0;
    checkCtrl("start", 1'b0, 1'b1, 1'b0);
    checkOutput("latch_off", global_fsm_s_output_mmap_offset, off);
    checkOutput("latch_len", 64'(global_fsm_s_seq_len), 64'(len));
    if (!holdStart) ap_start = 1'b0;
    s_output_mmap_offset = postOff;
    s_seq_len            = postLen;
    for (int r = 1; r <= endCycle; r++) begin
      tick();
      for (int i = 0; i < NumTasks; i++) task_is_done[i] = (r >= arr[i]);
      checkCtrl("run", 1'b0, 1'b0, 1'b0);
      if (r == 1) begin
        checkOutput("run_hold_len", 64'(global_fsm_s_seq_len), 64'(len));
      end
    end
    tick();
    expErr = timedOut;
    checkCtrl("done", 1'b0, 1'b0, 1'b1);
    checkOutput("done_rcyc", 64'(run_cycles), 64'(endCycle));
    task_is_done = '0;
    tick();
    checkCtrl("idle_post", 1'b1, 1'b0, 1'b0);
    checkOutput("idle_rcyc", 64'(run_cycles), 64'(endCycle));
    checkOutput("idle_hold_off", global_fsm_s_output_mmap_offset, off);
  endtask

  // Reset pulse in the middle of RUN with all done bits offered
  task automatic midRunReset();
    s_output_mmap_offset = {$urandom, $urandom};
    s_seq_len            = $urandom;
    ap_start             = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    task_is_done = '1;
    #3;
    ap_rst_n = 1'b0;
    expErr   = 1'b0;
    #1;
    checkResetValues("async_rst");
    tick();
    checkResetValues("rst_hold");
    task_is_done = '0;
    ap_rst_n     = 1'b1;
    tick();
    checkResetValues("rst_release");
  endtask

  initial begin
    int arr[NumTasks];
    $display("[TB] start");
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
    checkResetValues("reset");

    // Nominal run
    arr = '{2, 5, 5, 9};
    applyStimulus(64'h1000, 32'd128, arr, 1'b0, 64'h1000, 32'd128);

    // Partial done vector for 100 cycles
    arr = '{1, 1, 1, 101};
    applyStimulus(64'h2222, 32'd7, arr, 1'b0, 64'h0, 32'd0);

    // Back-to-back with ap_start held high
    arr = '{1, 3, 2, 1};
    applyStimulus(64'h3000, 32'd64, arr, 1'b1, 64'h4000, 32'd256);
    arr = '{1, 1, 1, 1};
    applyStimulus(64'h4000, 32'd256, arr, 1'b0, 64'h0, 32'd0);

    // Done bits never arrive within the limit, then exactly at the limit
    arr = '{200, 200, 200, 200};
    applyStimulus(64'h5000, 32'd5, arr, 1'b0, 64'h0, 32'd0);
    arr = '{3, 16, 16, 1};
    applyStimulus(64'h6000, 32'd6, arr, 1'b0, 64'h0, 32'd0);

    midRunReset();

    // Randomized invocations
    for (int n = 0; n < 24; n++) begin
      foreach (arr[i]) arr[i] = int'($urandom_range(1, 20));
      applyStimulus({$urandom, $urandom}, $urandom, arr, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, $urandom);
    end
    ap_start = 1'b0;

    midRunReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
